noc_output_scheduler: RTL and testbench

- Per-output-port scheduler for the NOC router.
- Shares one 64-bit output channel between NUM_REQ input-port requesters carrying flits on two virtual channels.
- Serves VC0 on even polarity cycles and VC1 on odd polarity cycles, round-robin among requesters of the active VC, gated by downstream credit counters.
- Sits between the input VC buffers (it pops them via grant) and the output link register.

---
 rtl/noc_pkg.sv | 27 ++
 rtl/noc_output_scheduler_rr_arbiter.sv | 24 ++
 rtl/noc_output_scheduler.sv | 151 +++++++++++++++
 tb/tb_noc_output_scheduler.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NOC definitions: flit width, virtual-channel ids, header
// field positions and a credit-counter width helper.
package noc_pkg;

   localparam int FLIT_W = 64;
   localparam int NUM_VC = 2;

   typedef enum logic {
      VC0 = 1'b0,
      VC1 = 1'b1
   } vc_e;

   // Header field positions inside the head flit, shared with the router arbiter.
   localparam int HDR_DEST_LSB = 0;
   localparam int HDR_DEST_W   = 4;
   localparam int HDR_SRC_LSB  = 4;
   localparam int HDR_SRC_W    = 4;
   localparam int HDR_VC_BIT   = 8;
   localparam int HDR_TYPE_LSB = 9;
   localparam int HDR_TYPE_W   = 2;

   // Minimum counter width able to hold the values 0..depth.
   function automatic int credit_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/noc_output_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester found when scanning
// upward from the pointer position, wrapping modulo N.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     grant_o
);

   logic found_s;

   // Priority scan starting at ptr_i; only the first hit is granted.
   always_comb begin
      grant_o = {N{1'b0}};
      found_s = 1'b0;
      for (int k = 0; k < N; k++) begin
         grant_o[(int'(ptr_i) + k) % N] = req_i[(int'(ptr_i) + k) % N] & ~found_s;
         found_s = found_s | req_i[(int'(ptr_i) + k) % N];
      end
   end

endmodule

// File: rtl/noc_output_scheduler.sv
// Per-output-port scheduler: one flit per cycle onto the output link,
// VC0 on even polarity and VC1 on odd polarity, round-robin among the
// requesters of the active VC, gated by downstream credit counters.
module noc_output_scheduler
   import noc_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int FLIT_W    = noc_pkg::FLIT_W,
   parameter int BUF_DEPTH = 4,
   parameter int CNT_W     = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      polarity,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_vc,
   input  logic [NUM_REQ*FLIT_W-1:0] din,
   input  logic [1:0]                credit_in,
   output logic [NUM_REQ-1:0]        grant,
   output logic [FLIT_W-1:0]         dout,
   output logic                      dout_valid,
   output logic                      dout_vc,
   output logic [CNT_W-1:0]          credit_cnt0,
   output logic [CNT_W-1:0]          credit_cnt1,
   output logic                      credit_err
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   vc_e                av_s;
   logic [NUM_REQ-1:0] vc_match_s;
   logic [NUM_REQ-1:0] eligible_s;
   logic               credit_ok_s;
   logic [NUM_REQ-1:0] grant_s;
   logic               any_grant_s;
   logic [PTR_W-1:0]   gnt_idx_s;
   logic [FLIT_W-1:0]  sel_flit_s;
   logic [1:0]         send_s;
   logic [1:0]         ovf_s;

   logic [FLIT_W-1:0]  dout_q, dout_d;
   logic               dout_valid_q, dout_valid_d;
   logic               dout_vc_q, dout_vc_d;
   logic [PTR_W-1:0]   ptr_q [2];
   logic [PTR_W-1:0]   ptr_d [2];
   logic [CNT_W-1:0]   credit_q [2];
   logic [CNT_W-1:0]   credit_d [2];
   logic               credit_err_q, credit_err_d;

   // Eligibility: matching VC, credit available, and never during reset.
   always_comb begin
      av_s        = vc_e'(polarity);
      vc_match_s  = (av_s == VC1) ? req_vc : ~req_vc;
      credit_ok_s = (av_s == VC1) ? (credit_q[1] != {CNT_W{1'b0}})
                                  : (credit_q[0] != {CNT_W{1'b0}});
      eligible_s  = req & vc_match_s & {NUM_REQ{credit_ok_s & reset}};
   end

   rr_arbiter #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) u_arb (
      .req_i   (eligible_s),
      .ptr_i   (ptr_q[polarity]),
      .grant_o (grant_s)
   );

   // Flit select and granted index from the one-hot grant.
   always_comb begin
      sel_flit_s = {FLIT_W{1'b0}};
      gnt_idx_s  = {PTR_W{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_flit_s = sel_flit_s | (din[i*FLIT_W +: FLIT_W] & {FLIT_W{grant_s[i]}});
         gnt_idx_s  = gnt_idx_s | (grant_s[i] ? PTR_W'(i) : {PTR_W{1'b0}});
      end
      any_grant_s = |grant_s;
   end

   // Output link next state and round-robin pointer advance for the active VC.
   always_comb begin
      dout_d       = dout_q;
      dout_vc_d    = dout_vc_q;
      dout_valid_d = any_grant_s;
      ptr_d[0]     = ptr_q[0];
      ptr_d[1]     = ptr_q[1];
      if (any_grant_s) begin
         dout_d    = sel_flit_s;
         dout_vc_d = polarity;
         ptr_d[polarity] = (gnt_idx_s == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}}
                                                              : gnt_idx_s + PTR_W'(1);
      end else begin
         dout_d    = dout_q;
         dout_vc_d = dout_vc_q;
      end
   end

   // Credit counters for both VCs: a send consumes, a return refills,
   // a return into a full counter raises the sticky error instead.
   always_comb begin
      send_s[0] = any_grant_s & (av_s == VC0);
      send_s[1] = any_grant_s & (av_s == VC1);
      for (int v = 0; v < 2; v++) begin
         credit_d[v] = credit_q[v];
         ovf_s[v]    = 1'b0;
         case ({send_s[v], credit_in[v]})
            2'b10: credit_d[v] = credit_q[v] - CNT_W'(1);
            2'b01: begin
               if (credit_q[v] < CNT_W'(BUF_DEPTH)) begin
                  credit_d[v] = credit_q[v] + CNT_W'(1);
               end else begin
                  ovf_s[v] = 1'b1;
               end
            end
            default: credit_d[v] = credit_q[v];
         endcase
      end
      credit_err_d = credit_err_q | ovf_s[0] | ovf_s[1];
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         dout_q       <= {FLIT_W{1'b0}};
         dout_valid_q <= 1'b0;
         dout_vc_q    <= 1'b0;
         ptr_q[0]     <= {PTR_W{1'b0}};
         ptr_q[1]     <= {PTR_W{1'b0}};
         credit_q[0]  <= CNT_W'(BUF_DEPTH);
         credit_q[1]  <= CNT_W'(BUF_DEPTH);
         credit_err_q <= 1'b0;
      end else begin
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         dout_vc_q    <= dout_vc_d;
         ptr_q[0]     <= ptr_d[0];
         ptr_q[1]     <= ptr_d[1];
         credit_q[0]  <= credit_d[0];
         credit_q[1]  <= credit_d[1];
         credit_err_q <= credit_err_d;
      end
   end

   assign grant       = grant_s;
   assign dout        = dout_q;
   assign dout_valid  = dout_valid_q;
   assign dout_vc     = dout_vc_q;
   assign credit_cnt0 = credit_q[0];
   assign credit_cnt1 = credit_q[1];
   assign credit_err  = credit_err_q;

endmodule

// File: tb/tb_noc_output_scheduler.sv
// Directed, table-driven bench for the output scheduler.
module tb_noc_output_scheduler;

   localparam logic [63:0] D0 = 64'h1000_0000_0000_0000;
   localparam logic [63:0] D1 = 64'h1000_0000_0000_0001;
   localparam logic [63:0] D2 = 64'h1000_0000_0000_0002;
   localparam logic [63:0] D3 = 64'h1000_0000_0000_0003;
   localparam logic [63:0] Z  = 64'h0;

   logic         clk;
   logic         reset;
   logic         polarity;
   logic [3:0]   req;
   logic [3:0]   req_vc;
   logic [255:0] din;
   logic [1:0]   credit_in;
   logic [3:0]   grant;
   logic [63:0]  dout;
   logic         dout_valid;
   logic         dout_vc;
   logic [2:0]   credit_cnt0;
   logic [2:0]   credit_cnt1;
   logic         credit_err;

   int checks;
   int failures;

   typedef struct {
      logic        rst;
      logic        pol;
      logic [3:0]  rq;
      logic [3:0]  vc;
      logic [1:0]  cin;
      logic [3:0]  g;
      logic        v;
      logic [63:0] d;
      logic        dvc;
      logic [2:0]  c0;
      logic [2:0]  c1;
      logic        err;
   } vec_t;

   vec_t vecs [26];

   noc_output_scheduler dut (
      .clk         (clk),
      .reset       (reset),
      .polarity    (polarity),
      .req         (req),
      .req_vc      (req_vc),
      .din         (din),
      .credit_in   (credit_in),
      .grant       (grant),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .dout_vc     (dout_vc),
      .credit_cnt0 (credit_cnt0),
      .credit_cnt1 (credit_cnt1),
      .credit_err  (credit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic rst, input logic pol, input logic [3:0] rq,
                               input logic [3:0] vc, input logic [1:0] cin, input logic [3:0] g,
                               input logic v, input logic [63:0] d, input logic dvc,
                               input logic [2:0] c0, input logic [2:0] c1, input logic err);
      vec_t r;
      r.rst = rst; r.pol = pol; r.rq = rq; r.vc = vc; r.cin = cin; r.g = g;
      r.v = v; r.d = d; r.dvc = dvc; r.c0 = c0; r.c1 = c1; r.err = err;
      return r;
   endfunction

   task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   // Drive one cycle of inputs, check the combinational grant before the
   // edge and the registered outputs just after it.
   task automatic run_vec(input int idx, input vec_t t);
      reset     = t.rst;
      polarity  = t.pol;
      req       = t.rq;
      req_vc    = t.vc;
      credit_in = t.cin;
      #1;
      chk("grant", idx, 64'(grant), 64'(t.g));
      @(posedge clk);
      #1;
      chk("dout_valid", idx, 64'(dout_valid), 64'(t.v));
      chk("dout", idx, dout, t.d);
      if (t.v) chk("dout_vc", idx, 64'(dout_vc), 64'(t.dvc));
      chk("credit_cnt0", idx, 64'(credit_cnt0), 64'(t.c0));
      chk("credit_cnt1", idx, 64'(credit_cnt1), 64'(t.c1));
      chk("credit_err", idx, 64'(credit_err), 64'(t.err));
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b0;
      polarity  = 1'b0;
      req       = 4'b0000;
      req_vc    = 4'b0000;
      credit_in = 2'b00;
      for (int i = 0; i < 4; i++) din[i*64 +: 64] = D0 | 64'(i);

      //               rst  pol  req      vc       cin    grant    v    dout vc   c0    c1    err
      // Reset then idle
      vecs[0]  = mk(1'b0, 1'b0, 4'b0000, 4'b0000, 2'b00, 4'b0000, 1'b0, Z,  1'b0, 3'd4, 3'd4, 1'b0);
      vecs[1]  = mk(1'b0, 1'b1, 4'b0000, 4'b0000, 2'b00, 4'b0000, 1'b0, Z,  1'b0, 3'd4, 3'd4, 1'b0);
      // Round-robin within VC0 until credits run out
      vecs[2]  = mk(1'b1, 1'b0, 4'b1111, 4'b0000, 2'b00, 4'b0001, 1'b1, D0, 1'b0, 3'd3, 3'd4, 1'b0);
      vecs[3]  = mk(1'b1, 1'b1, 4'b1111, 4'b0000, 2'b00, 4'b0000, 1'b0, D0, 1'b0, 3'd3, 3'd4, 1'b0);
      vecs[4]  = mk(1'b1, 1'b0, 4'b1111, 4'b0000, 2'b00, 4'b0010, 1'b1, D1, 1'b0, 3'd2, 3'd4, 1'b0);
      vecs[5]  = mk(1'b1, 1'b1, 4'b1111, 4'b0000, 2'b00, 4'b0000, 1'b0, D1, 1'b0, 3'd2, 3'd4, 1'b0);
      vecs[6]  = mk(1'b1, 1'b0, 4'b1111, 4'b0000, 2'b00, 4'b0100, 1'b1, D2, 1'b0, 3'd1, 3'd4, 1'b0);
      vecs[7]  = mk(1'b1, 1'b1, 4'b1111, 4'b0000, 2'b00, 4'b0000, 1'b0, D2, 1'b0, 3'd1, 3'd4, 1'b0);
      vecs[8]  = mk(1'b1, 1'b0, 4'b1111, 4'b0000, 2'b00, 4'b1000, 1'b1, D3, 1'b0, 3'd0, 3'd4, 1'b0);
      vecs[9]  = mk(1'b1, 1'b1, 4'b1111, 4'b0000, 2'b00, 4'b0000, 1'b0, D3, 1'b0, 3'd0, 3'd4, 1'b0);
      // Credit returned this cycle does not enable a grant this cycle
      vecs[10] = mk(1'b1, 1'b0, 4'b1111, 4'b0000, 2'b01, 4'b0000, 1'b0, D3, 1'b0, 3'd1, 3'd4, 1'b0);
      // Alternating VCs, including simultaneous send and credit return
      vecs[11] = mk(1'b1, 1'b1, 4'b0011, 4'b0010, 2'b01, 4'b0010, 1'b1, D1, 1'b1, 3'd2, 3'd3, 1'b0);
      vecs[12] = mk(1'b1, 1'b0, 4'b0011, 4'b0010, 2'b01, 4'b0001, 1'b1, D0, 1'b0, 3'd2, 3'd3, 1'b0);
      vecs[13] = mk(1'b1, 1'b1, 4'b0011, 4'b0010, 2'b10, 4'b0010, 1'b1, D1, 1'b1, 3'd2, 3'd3, 1'b0);
      vecs[14] = mk(1'b1, 1'b0, 4'b0011, 4'b0010, 2'b00, 4'b0001, 1'b1, D0, 1'b0, 3'd1, 3'd3, 1'b0);
      // Drain VC1 credits with requester 2, then starve and recover
      vecs[15] = mk(1'b1, 1'b1, 4'b0100, 4'b0100, 2'b00, 4'b0100, 1'b1, D2, 1'b1, 3'd1, 3'd2, 1'b0);
      vecs[16] = mk(1'b1, 1'b0, 4'b0100, 4'b0100, 2'b00, 4'b0000, 1'b0, D2, 1'b0, 3'd1, 3'd2, 1'b0);
      vecs[17] = mk(1'b1, 1'b1, 4'b0100, 4'b0100, 2'b00, 4'b0100, 1'b1, D2, 1'b1, 3'd1, 3'd1, 1'b0);
      vecs[18] = mk(1'b1, 1'b0, 4'b0100, 4'b0100, 2'b00, 4'b0000, 1'b0, D2, 1'b0, 3'd1, 3'd1, 1'b0);
      vecs[19] = mk(1'b1, 1'b1, 4'b0100, 4'b0100, 2'b00, 4'b0100, 1'b1, D2, 1'b1, 3'd1, 3'd0, 1'b0);
      vecs[20] = mk(1'b1, 1'b0, 4'b0100, 4'b0100, 2'b00, 4'b0000, 1'b0, D2, 1'b0, 3'd1, 3'd0, 1'b0);
      vecs[21] = mk(1'b1, 1'b1, 4'b0100, 4'b0100, 2'b10, 4'b0000, 1'b0, D2, 1'b0, 3'd1, 3'd1, 1'b0);
      vecs[22] = mk(1'b1, 1'b0, 4'b0100, 4'b0100, 2'b00, 4'b0000, 1'b0, D2, 1'b0, 3'd1, 3'd1, 1'b0);
      vecs[23] = mk(1'b1, 1'b1, 4'b0100, 4'b0100, 2'b00, 4'b0100, 1'b1, D2, 1'b1, 3'd1, 3'd0, 1'b0);
      vecs[24] = mk(1'b1, 1'b0, 4'b0100, 4'b0100, 2'b10, 4'b0000, 1'b0, D2, 1'b0, 3'd1, 3'd1, 1'b0);
      vecs[25] = mk(1'b1, 1'b1, 4'b0100, 4'b0100, 2'b00, 4'b0100, 1'b1, D2, 1'b1, 3'd1, 3'd0, 1'b0);

      for (int i = 0; i < 26; i++) run_vec(i, vecs[i]);

      // Refill VC0 to full, then overflow it: error is raised and stays set.
      run_vec(100, mk(1'b1, 1'b0, 4'b0000, 4'b0000, 2'b01, 4'b0000, 1'b0, D2, 1'b0, 3'd2, 3'd0, 1'b0));
      run_vec(101, mk(1'b1, 1'b1, 4'b0000, 4'b0000, 2'b01, 4'b0000, 1'b0, D2, 1'b0, 3'd3, 3'd0, 1'b0));
      run_vec(102, mk(1'b1, 1'b0, 4'b0000, 4'b0000, 2'b01, 4'b0000, 1'b0, D2, 1'b0, 3'd4, 3'd0, 1'b0));
      run_vec(103, mk(1'b1, 1'b1, 4'b0000, 4'b0000, 2'b01, 4'b0000, 1'b0, D2, 1'b0, 3'd4, 3'd0, 1'b1));
      run_vec(104, mk(1'b1, 1'b0, 4'b0000, 4'b0000, 2'b00, 4'b0000, 1'b0, D2, 1'b0, 3'd4, 3'd0, 1'b1));

      // Mid-stream reset with all requesters active: no grant, state cleared.
      run_vec(105, mk(1'b0, 1'b0, 4'b1111, 4'b0000, 2'b00, 4'b0000, 1'b0, Z,  1'b0, 3'd4, 3'd4, 1'b0));
      run_vec(106, mk(1'b0, 1'b1, 4'b1111, 4'b1111, 2'b00, 4'b0000, 1'b0, Z,  1'b0, 3'd4, 3'd4, 1'b0));

      // Both pointers restart at requester 0 after reset.
      run_vec(107, mk(1'b1, 1'b0, 4'b1111, 4'b0000, 2'b00, 4'b0001, 1'b1, D0, 1'b0, 3'd3, 3'd4, 1'b0));
      run_vec(108, mk(1'b1, 1'b1, 4'b1111, 4'b1111, 2'b00, 4'b0001, 1'b1, D0, 1'b1, 3'd3, 3'd3, 1'b0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
